// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm sequencing controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_e;

    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned HH_W        = 5;
    localparam int unsigned MM_W        = 6;
    localparam int unsigned SS_W        = 6;

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Time/button inputs and status outputs between the alarm datapath and the ring controller.
interface alarm_ring_ctrl_if;
    import alarm_pkg::*;

    logic            tick_1hz;
    logic [HH_W-1:0] cur_hh;
    logic [MM_W-1:0] cur_mm;
    logic [SS_W-1:0] cur_ss;
    logic [HH_W-1:0] alm_hh;
    logic [MM_W-1:0] alm_mm;
    logic            arm_en;
    logic            snooze_btn;
    logic            stop_btn;
    logic            ringing;
    logic            snoozing;
    logic            buzzer;
    logic [1:0]      state_o;

    modport master (
        output tick_1hz, cur_hh, cur_mm, cur_ss, alm_hh, alm_mm,
               arm_en, snooze_btn, stop_btn,
        input  ringing, snoozing, buzzer, state_o
    );

    modport slave (
        input  tick_1hz, cur_hh, cur_mm, cur_ss, alm_hh, alm_mm,
               arm_en, snooze_btn, stop_btn,
        output ringing, snoozing, buzzer, state_o
    );

endinterface

// File: rtl/alarm_tone_gen.sv
// Buzzer square-wave divider (TONE_DIV clk per half-period) gated by beep phase and ring state.
module alarm_tone_gen #(
    parameter int unsigned TONE_DIV = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic beep_on_i,
    input  logic ring_i,
    output logic buzzer_o
);

    localparam int unsigned     CNT_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TONE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;
    logic             buzzer_q, buzzer_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tone_d = tone_q;
        if (clear_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end
        buzzer_d = tone_q & beep_on_i & ring_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer_o = buzzer_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm arm/ring/snooze/stop sequencer with registered status flags and gated buzzer.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps consecutive snoozes at three per ring episode.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned TONE_DIV       = 12
) (
    input  logic             clk,
    input  logic             reset,
    alarm_ring_ctrl_if.slave bus
);

    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * SEC_PER_MIN - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

    alarm_state_e state_q, state_d;
    logic [7:0]   ring_cnt_q, ring_cnt_d;
    logic [9:0]   snz_cnt_q, snz_cnt_d;
    logic         beep_q, beep_d;
    logic         ringing_q, snoozing_q;
    logic         time_match;
    logic         enter_ring;
    logic         snooze_ok;

    assign time_match = (bus.cur_hh == bus.alm_hh) && (bus.cur_mm == bus.alm_mm)
                     && (bus.cur_ss == '0);

`ifdef ALARM_SNOOZE_LIMIT_EN
    logic [1:0] snooze_used_q, snooze_used_d;

    assign snooze_ok = (snooze_used_q != 2'd3);

    always_comb begin
        snooze_used_d = snooze_used_q;
        if (state_d == ARMED && state_q != ARMED) begin
            snooze_used_d = '0;
        end else if (state_q == RINGING && state_d == SNOOZE) begin
            snooze_used_d = snooze_used_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) snooze_used_q <= '0;
        else       snooze_used_q <= snooze_used_d;
    end
`else
    assign snooze_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        beep_d     = beep_q;
        enter_ring = 1'b0;

        if (!bus.arm_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (bus.tick_1hz && time_match) state_d = RINGING;
                RINGING: begin
                    // Stop and timeout both outrank snooze, even in the same clk.
                    if (bus.stop_btn) begin
                        state_d = ARMED;
                    end else if (bus.tick_1hz && ring_cnt_q == RING_LAST) begin
                        state_d = ARMED;
                    end else if (bus.snooze_btn && snooze_ok) begin
                        state_d = SNOOZE;
                    end else if (bus.tick_1hz) begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                        beep_d     = ~beep_q;
                    end
                end
                SNOOZE: begin
                    if (bus.stop_btn) begin
                        state_d = ARMED;
                    end else if (bus.tick_1hz) begin
                        if (snz_cnt_q == '0) state_d = RINGING;
                        else                 snz_cnt_d = snz_cnt_q - 10'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == RINGING && state_q != RINGING) begin
            enter_ring = 1'b1;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
        end
        if (state_d == SNOOZE && state_q != SNOOZE) begin
            snz_cnt_d = SNZ_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            beep_q     <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_q     <= beep_d;
            ringing_q  <= (state_d == RINGING);
            snoozing_q <= (state_d == SNOOZE);
        end
    end

    alarm_tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (enter_ring),
        .beep_on_i (beep_q),
        .ring_i    (state_q == RINGING),
        .buzzer_o  (bus.buzzer)
    );

    assign bus.ringing  = ringing_q;
    assign bus.snoozing = snoozing_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: vector table, directed corner sequences, random run vs model.
module tb_alarm_ring_ctrl;

    localparam int SNOOZE_MIN     = 5;
    localparam int RING_TIMEOUT_S = 60;
    localparam int TONE_DIV       = 12;
`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alarm_ring_ctrl_if bus ();

    alarm_ring_ctrl #(
        .SNOOZE_MIN     (SNOOZE_MIN),
        .RING_TIMEOUT_S (RING_TIMEOUT_S),
        .TONE_DIV       (TONE_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing.
    int m_mode = 0;
    int m_secs_rung = 0;     // completed seconds in the current ring episode
    int m_snz_left = 0;      // seconds left before re-ringing
    int m_cyc = 0;           // clocks since ringing began
    int m_snoozes = 0;
    bit m_buz = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit audible;
        int nxt;
        bit match;
        audible = (m_mode == 2) && (m_secs_rung % 2 == 0) && ((m_cyc / TONE_DIV) % 2 == 1);
        match = (bus.cur_hh == bus.alm_hh) && (bus.cur_mm == bus.alm_mm) && (bus.cur_ss == 0);
        if (reset) begin
            m_mode = 0; m_secs_rung = 0; m_snz_left = 0; m_cyc = 0; m_snoozes = 0; m_buz = 1'b0;
        end else begin
            m_buz = audible;
            nxt = m_mode;
            if (!bus.arm_en) nxt = 0;
            else if (m_mode == 0) nxt = 1;
            else if (m_mode == 1) begin
                if (bus.tick_1hz && match) nxt = 2;
            end else if (m_mode == 2) begin
                if (bus.stop_btn) nxt = 1;
                else if (bus.tick_1hz && m_secs_rung + 1 == RING_TIMEOUT_S) nxt = 1;
                else if (bus.snooze_btn && (!LIMIT || m_snoozes < 3)) begin
                    nxt = 3;
                    m_snz_left = SNOOZE_MIN * 60;
                    m_snoozes++;
                end else if (bus.tick_1hz) m_secs_rung++;
            end else begin
                if (bus.stop_btn) nxt = 1;
                else if (bus.tick_1hz) begin
                    m_snz_left--;
                    if (m_snz_left == 0) nxt = 2;
                end
            end
            if (nxt == 1 && m_mode != 1) m_snoozes = 0;
            if (nxt == 2 && m_mode != 2) begin
                m_secs_rung = 0;
                m_cyc = 0;
            end else begin
                m_cyc++;
            end
            m_mode = nxt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model", {bus.state_o, bus.ringing, bus.snoozing, bus.buzzer},
              {m_mode[1:0], m_mode == 2, m_mode == 3, m_buz});
    endtask

    task automatic set_time(input int hh, input int mm, input int ss);
        bus.cur_hh = 5'(hh);
        bus.cur_mm = 6'(mm);
        bus.cur_ss = 6'(ss);
    endtask

    task automatic tick_at(input int hh, input int mm, input int ss);
        set_time(hh, mm, ss);
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic press(input bit snz, input bit stp);
        bus.snooze_btn = snz;
        bus.stop_btn   = stp;
        step();
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
    endtask

    task automatic reset_and_trigger();
        reset = 1'b1;
        bus.arm_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        tick_at(7, 29, 59);
        check("pre_trigger_state", bus.state_o, 1);
        tick_at(7, 30, 0);
        check("trigger_ringing", bus.ringing, 1);
    endtask

    typedef struct {
        bit rst, arm, tick;
        int hh, mm, ss;
        bit snz, stp;
        int st, ring, snzo;
    } vec_t;

    vec_t vecs[24];

    initial begin
        bus.tick_1hz = 1'b0; bus.arm_en = 1'b0;
        bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;
        bus.alm_hh = 5'd7; bus.alm_mm = 6'd30;
        set_time(7, 29, 59);

        //          rst arm tk  hh  mm  ss snz stp  st ring snz
        vecs[0]  = '{1, 0, 0,  7, 29, 59, 0, 0,  0, 0, 0};
        vecs[1]  = '{0, 0, 0,  7, 29, 59, 0, 0,  0, 0, 0};
        vecs[2]  = '{0, 1, 0,  7, 29, 59, 0, 0,  1, 0, 0};
        vecs[3]  = '{0, 1, 1,  7, 29, 59, 0, 0,  1, 0, 0};
        vecs[4]  = '{0, 1, 0,  7, 30,  0, 0, 0,  1, 0, 0};
        vecs[5]  = '{0, 1, 1,  7, 30,  1, 0, 0,  1, 0, 0};
        vecs[6]  = '{0, 1, 0,  7, 30,  1, 1, 0,  1, 0, 0};
        vecs[7]  = '{0, 1, 0,  7, 30,  1, 0, 1,  1, 0, 0};
        vecs[8]  = '{0, 1, 1,  7, 30,  0, 0, 0,  2, 1, 0};
        vecs[9]  = '{0, 1, 0,  7, 30,  0, 0, 0,  2, 1, 0};
        vecs[10] = '{0, 1, 0,  7, 30,  0, 1, 0,  3, 0, 1};
        vecs[11] = '{0, 1, 0,  7, 30,  0, 1, 0,  3, 0, 1};
        vecs[12] = '{0, 1, 1,  7, 30,  1, 0, 0,  3, 0, 1};
        vecs[13] = '{0, 1, 0,  7, 30,  1, 0, 1,  1, 0, 0};
        vecs[14] = '{0, 1, 1,  7, 30,  0, 0, 0,  2, 1, 0};
        vecs[15] = '{0, 1, 0,  7, 30,  0, 1, 1,  1, 0, 0};
        vecs[16] = '{0, 1, 1,  7, 30,  0, 0, 0,  2, 1, 0};
        vecs[17] = '{0, 0, 0,  7, 30,  0, 0, 0,  0, 0, 0};
        vecs[18] = '{0, 0, 1,  7, 30,  0, 0, 0,  0, 0, 0};
        vecs[19] = '{0, 1, 0,  7, 30,  0, 0, 0,  1, 0, 0};
        vecs[20] = '{0, 1, 1,  8, 30,  0, 0, 0,  1, 0, 0};
        vecs[21] = '{0, 1, 1,  7, 31,  0, 0, 0,  1, 0, 0};
        vecs[22] = '{0, 1, 1,  7, 30,  0, 0, 0,  2, 1, 0};
        vecs[23] = '{1, 1, 0,  7, 30,  0, 0, 0,  0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            reset = vecs[i].rst;
            bus.arm_en = vecs[i].arm;
            bus.tick_1hz = vecs[i].tick;
            set_time(vecs[i].hh, vecs[i].mm, vecs[i].ss);
            bus.snooze_btn = vecs[i].snz;
            bus.stop_btn = vecs[i].stp;
            step();
            check($sformatf("vec%0d_state", i), bus.state_o, vecs[i].st);
            check($sformatf("vec%0d_ringing", i), bus.ringing, vecs[i].ring);
            check($sformatf("vec%0d_snoozing", i), bus.snoozing, vecs[i].snzo);
        end
        reset = 1'b0; bus.tick_1hz = 1'b0; bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;

        // Trigger, tone period, then timeout on the 60th tick.
        reset_and_trigger();
        for (int n = 1; n <= 48; n++) begin
            step();
            check($sformatf("tone_n%0d", n), bus.buzzer, ((n - 1) / TONE_DIV) % 2);
        end
        for (int k = 1; k <= 59; k++) begin
            tick_at(7, 30, k);
            step();
        end
        check("ringing_after_59_ticks", bus.ringing, 1);
        tick_at(7, 31, 0);
        check("timeout_state", bus.state_o, 1);
        check("timeout_buzzer_0", bus.buzzer, 0);
        step();
        check("timeout_buzzer_1", bus.buzzer, 0);
        for (int k = 1; k <= 5; k++) tick_at(7, 31, k);
        check("timeout_no_retrigger", bus.state_o, 1);

        // Stop, then the rest of the matching minute must not retrigger.
        reset_and_trigger();
        press(1'b0, 1'b1);
        check("stop_state", bus.state_o, 1);
        for (int k = 1; k <= 59; k++) tick_at(7, 30, k);
        check("stop_no_retrigger", bus.state_o, 1);

        // Snooze lasts exactly SNOOZE_MIN*60 ticks.
        reset_and_trigger();
        press(1'b1, 1'b0);
        check("snooze_flag", bus.snoozing, 1);
        for (int k = 1; k < SNOOZE_MIN * 60; k++) tick_at(7, 35, k % 60);
        check("snooze_before_last_tick", bus.snoozing, 1);
        tick_at(7, 40, 0);
        check("snooze_reringing", bus.ringing, 1);
        press(1'b0, 1'b1);
        check("snooze_stop", bus.state_o, 1);

        // Disarm while snoozing.
        reset_and_trigger();
        press(1'b1, 1'b0);
        bus.arm_en = 1'b0;
        step();
        check("disarm_snooze_state", bus.state_o, 0);
        bus.arm_en = 1'b1;

        // Reset while the buzzer is sounding.
        reset_and_trigger();
        for (int n = 1; n <= 13; n++) step();
        check("buzzer_before_reset", bus.buzzer, 1);
        reset = 1'b1;
        step();
        check("reset_outputs", {bus.state_o, bus.ringing, bus.snoozing, bus.buzzer}, 0);
        reset = 1'b0;

`ifdef ALARM_SNOOZE_LIMIT_EN
        reset_and_trigger();
        for (int s = 0; s < 3; s++) begin
            press(1'b1, 1'b0);
            for (int k = 1; k <= SNOOZE_MIN * 60; k++) tick_at(7, 45, k % 60);
            check($sformatf("limit_rering%0d", s), bus.ringing, 1);
        end
        press(1'b1, 1'b0);
        check("limit_fourth_ignored", bus.state_o, 2);
        press(1'b0, 1'b1);
        check("limit_stop", bus.state_o, 1);
`endif

        // Random run against the reference model.
        for (int c = 0; c < 20000; c++) begin
            reset = ($urandom_range(0, 999) == 0);
            bus.arm_en = ($urandom_range(0, 1999) != 0);
            bus.tick_1hz = ($urandom_range(0, 2) == 0);
            bus.cur_hh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 23)) : 5'd7;
            bus.cur_mm = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 59)) : 6'd30;
            bus.cur_ss = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
            bus.snooze_btn = ($urandom_range(0, 99) == 0);
            bus.stop_btn = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
